// File: rtl/rcpu_boot_loader.sv
// Boot sequencer for rcpu: loads a framed UART image into RAM, then releases the CPU and passes its RAM writes through.
// Optional macro BOOT_CHECKSUM_EN: expect a trailing XOR checksum byte before releasing the CPU.
module rcpu_boot_loader #(
  parameter int         MAX_WORDS = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        boot_req,
  output logic        cpu_resetq,
  input  logic        cpu_mem_write_enable,
  input  logic [15:0] cpu_mem_write_address,
  input  logic [15:0] cpu_mem_write_data,
  output logic        mem_write_enable,
  output logic [15:0] mem_write_address,
  output logic [15:0] mem_write_data,
  output logic        busy,
  output logic        boot_error
);

  localparam int CW = $clog2(MAX_WORDS) + 1;

  typedef enum logic [3:0] {
    S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_FINISH, S_RUN, S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      hi_q, hi_d;
  logic [7:0]      csum_q, csum_d;
  logic            we_q, we_d;
  logic [15:0]     wa_q, wa_d;
  logic [15:0]     wd_q, wd_d;
  logic            cpu_resetq_q, busy_q, boot_error_q;

  logic [15:0]     len_new;
  logic [CW-1:0]   cnt_inc;

  assign len_new = {len_q[15:8], rx_data};
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    if (boot_req) begin
      // Abort wins over any same-cycle byte or pending loader write.
      state_d = S_SYNC;
      len_d   = '0;
      cnt_d   = '0;
      csum_d  = '0;
    end else begin
      case (state_q)
        S_SYNC:
          if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN_HI;
        S_LEN_HI:
          if (rx_valid) begin
            len_d   = {rx_data, len_q[7:0]};
            state_d = S_LEN_LO;
          end
        S_LEN_LO:
          if (rx_valid) begin
            len_d = len_new;
            if (len_new == 16'd0)                    state_d = S_FINISH;
            else if (len_new > 16'(MAX_WORDS))       state_d = S_ERROR;
            else                                     state_d = S_DATA_HI;
          end
        S_DATA_HI:
          if (rx_valid) begin
            hi_d    = rx_data;
            csum_d  = csum_q ^ rx_data;
            state_d = S_DATA_LO;
          end
        S_DATA_LO:
          if (rx_valid) begin
            we_d    = 1'b1;
            wa_d    = 16'(cnt_q);
            wd_d    = {hi_q, rx_data};
            cnt_d   = cnt_inc;
            csum_d  = csum_q ^ rx_data;
            state_d = (16'(cnt_inc) == len_q) ? S_FINISH : S_DATA_HI;
          end
        S_FINISH: begin
`ifdef BOOT_CHECKSUM_EN
          if (rx_valid) state_d = (rx_data == csum_q) ? S_RUN : S_ERROR;
`else
          state_d = S_RUN;
`endif
        end
        S_RUN: begin
          we_d = cpu_mem_write_enable;
          wa_d = cpu_mem_write_address;
          wd_d = cpu_mem_write_data;
        end
        S_ERROR: ;
        default: state_d = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q      <= S_SYNC;
      len_q        <= '0;
      cnt_q        <= '0;
      hi_q         <= '0;
      csum_q       <= '0;
      we_q         <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
      cpu_resetq_q <= 1'b0;
      busy_q       <= 1'b1;
      boot_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      csum_q       <= csum_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      // Status outputs track the state being entered so they align with it.
      cpu_resetq_q <= (state_d == S_RUN);
      busy_q       <= (state_d != S_RUN);
      boot_error_q <= (state_d == S_ERROR);
    end
  end

  assign cpu_resetq        = cpu_resetq_q;
  assign busy              = busy_q;
  assign boot_error        = boot_error_q;
  assign mem_write_enable  = we_q;
  assign mem_write_address = wa_q;
  assign mem_write_data    = wd_q;

endmodule

// File: tb/tb_rcpu_boot_loader.sv
// Scoreboard bench for rcpu_boot_loader: stimulus pushes expected RAM writes, a monitor pops on every write pulse.
module tb_rcpu_boot_loader;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        boot_req = 1'b0;
  logic        cpu_resetq;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_wa = '0;
  logic [15:0] cpu_wd = '0;
  logic        mem_write_enable;
  logic [15:0] mem_write_address;
  logic [15:0] mem_write_data;
  logic        busy;
  logic        boot_error;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];

  rcpu_boot_loader dut (
    .clk                   (clk),
    .resetq                (resetq),
    .rx_valid              (rx_valid),
    .rx_data               (rx_data),
    .boot_req              (boot_req),
    .cpu_resetq            (cpu_resetq),
    .cpu_mem_write_enable  (cpu_we),
    .cpu_mem_write_address (cpu_wa),
    .cpu_mem_write_data    (cpu_wd),
    .mem_write_enable      (mem_write_enable),
    .mem_write_address     (mem_write_address),
    .mem_write_data        (mem_write_data),
    .busy                  (busy),
    .boot_error            (boot_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_boot();
    boot_req = 1'b1;
    @(posedge clk); #1;
    boot_req = 1'b0;
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every write pulse cycle must match the next queued write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {mem_write_address, mem_write_data}, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {16'h0, mem_write_address}, {16'h0, e.a});
          check("wr_data", {16'h0, mem_write_data}, {16'h0, e.d});
        end
      end
    end
  end

  initial begin
    // Reset state
    idle(2);
    check("rst_cpu_resetq", {31'h0, cpu_resetq}, 32'd0);
    check("rst_busy",       {31'h0, busy}, 32'd1);
    check("rst_boot_error", {31'h0, boot_error}, 32'd0);
    check("rst_mem_we",     {31'h0, mem_write_enable}, 32'd0);
    check("rst_mem_addr_data", {mem_write_address, mem_write_data}, 32'd0);
    resetq = 1'b1;
    idle(1);

    // Basic two-word image; leading 00 is noise
    expect_wr(16'h0000, 16'h1234);
    expect_wr(16'h0001, 16'hABCD);
    send(8'h00); send(8'hA5);
    check("load_busy", {31'h0, busy}, 32'd1);
    send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    check("load_cpu_held", {31'h0, cpu_resetq}, 32'd0);
`ifdef BOOT_CHECKSUM_EN
    send(8'h40);
`endif
    idle(2);
    check("run_cpu_resetq", {31'h0, cpu_resetq}, 32'd1);
    check("run_busy",       {31'h0, busy}, 32'd0);

    // CPU write pass-through in RUN
    expect_wr(16'h0010, 16'hBEEF);
    cpu_we = 1'b1; cpu_wa = 16'h0010; cpu_wd = 16'hBEEF;
    idle(1);
    cpu_we = 1'b0; cpu_wa = '0; cpu_wd = '0;
    idle(2);

    // Length exactly MAX_WORDS accepted; abort suppresses the pending write
    pulse_boot();
    check("boot_cpu_resetq", {31'h0, cpu_resetq}, 32'd0);
    check("boot_busy",       {31'h0, busy}, 32'd1);
    send(8'hA5); send(8'h04); send(8'h00);
    check("len1024_no_error", {31'h0, boot_error}, 32'd0);
    send(8'h11);
    boot_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h22;
    @(posedge clk); #1;
    boot_req = 1'b0; rx_valid = 1'b0;
    idle(2);

    // Oversize image -> ERROR; bytes and CPU writes ignored there
    send(8'hA5); send(8'h04); send(8'h01);
    check("err_boot_error", {31'h0, boot_error}, 32'd1);
    check("err_cpu_resetq", {31'h0, cpu_resetq}, 32'd0);
    send(8'hA5); send(8'h00); send(8'h01); send(8'h11); send(8'h22);
    cpu_we = 1'b1; cpu_wa = 16'h0020; cpu_wd = 16'hDEAD;
    idle(2);
    cpu_we = 1'b0;
    check("err_sticky", {31'h0, boot_error}, 32'd1);
    pulse_boot();
    check("err_cleared", {31'h0, boot_error}, 32'd0);

    // Zero-length image goes straight to RUN
    send(8'hA5); send(8'h00); send(8'h00);
`ifdef BOOT_CHECKSUM_EN
    send(8'h00);
`endif
    idle(2);
    check("len0_run", {31'h0, cpu_resetq}, 32'd1);

    // boot_req in RUN beats a concurrent sync byte
    boot_req = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
    @(posedge clk); #1;
    boot_req = 1'b0; rx_valid = 1'b0;
    check("reboot_cpu_held", {31'h0, cpu_resetq}, 32'd0);
    expect_wr(16'h0000, 16'h55AA);
    send(8'hA5); send(8'h00); send(8'h01); send(8'h55); send(8'hAA);
`ifdef BOOT_CHECKSUM_EN
    send(8'hFF);
`endif
    idle(2);
    check("reload_run", {31'h0, cpu_resetq}, 32'd1);
    check("reload_no_error", {31'h0, boot_error}, 32'd0);

`ifdef BOOT_CHECKSUM_EN
    // Wrong checksum: data still written, then ERROR
    pulse_boot();
    expect_wr(16'h0000, 16'h1234);
    send(8'hA5); send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h00);
    idle(1);
    check("csum_err", {31'h0, boot_error}, 32'd1);
    check("csum_cpu_held", {31'h0, cpu_resetq}, 32'd0);
`endif

    // Asynchronous reset in DATA_LO discards progress
    pulse_boot();
    expect_wr(16'h0000, 16'h1234);
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'h56);
    #2 resetq = 1'b0;
    #1;
    check("arst_mem_data", {16'h0, mem_write_data}, 32'd0);
    check("arst_busy",     {31'h0, busy}, 32'd1);
    check("arst_cpu",      {31'h0, cpu_resetq}, 32'd0);
    idle(2);
    resetq = 1'b1;
    idle(1);
    expect_wr(16'h0000, 16'h9ABC);
    send(8'h00); send(8'h01); send(8'h12); send(8'h34);
    send(8'hA5); send(8'h00); send(8'h01); send(8'h9A); send(8'hBC);
`ifdef BOOT_CHECKSUM_EN
    send(8'h26);
`endif
    idle(3);
    check("arst_reload_run", {31'h0, cpu_resetq}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
